fft_addr_sched: RTL and testbench
=================================

FFT_ADDR_SCHED -- requirements
Module: fft_addr_sched

Interface
REQ-001 Parameter N, default 8, meaning FFT points; power of two, at least 8.
REQ-002 Local L = $clog2(N) (stage count); AW = L (address width); TW = L-1 (twiddle index width).
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_start  input  1  one-cycle request to start a full N-point radix-2 DIF address sequence.
REQ-006 o_busy  output  1  high from the cycle after an accepted start until o_done.
REQ-007 o_done  output  1  one-cycle pulse after the last butterfly is accepted.
REQ-008 o_tw_num  output  TW  twiddle index; drives i_num of the twiddle ROM, which has 1-cycle read latency.
REQ-009 o_valid  output  1  o_addr_a, o_addr_b, o_stage and o_last hold a butterfly.
REQ-010 i_ready  input  1  downstream accepts the butterfly when o_valid && i_ready.
REQ-011 o_addr_a / o_addr_b  output  AW each  butterfly operand addresses.
REQ-012 o_stage  output  AW  stage of the presented butterfly, 0..L-1.
REQ-013 o_last  output  1  presented butterfly is the final one of the final stage.

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN. IDLE->ISSUE on i_start. ISSUE->DRAIN when the last counter value moves to the output stage. DRAIN->IDLE when that butterfly is accepted; o_done pulses on the same edge.
REQ-015 i_start is ignored outside IDLE.
REQ-016 Counters: stage s in 0..L-1 and butterfly b in 0..N/2-1. b increments per advance. On b wrap, s increments.
REQ-017 Address math, with h = N>>(s+1), g = b/h and j = b%h:
- addr_a = g*2h + j
- addr_b = addr_a + h
- tw = j<<s, truncated to TW bits
- all computed by shifts and masks only; no dividers.
REQ-018 Two-stage pipe:
- Counter stage A holds the next butterfly.
- Output register B drives o_valid and the butterfly outputs.
- advance = !o_valid || i_ready.
- On advance, B loads A's butterfly and o_valid loads (state==ISSUE).
REQ-019 Twiddle alignment:
- o_tw_num = tw(A) when advance.
- o_tw_num = tw of the butterfly held in B when not advance.
- Result: ROM output is valid and stable, aligned with o_valid, for every cycle o_valid is high, stalls included.
REQ-020 Throughput is one butterfly per cycle while i_ready is held high. First o_valid appears 2 cycles after i_start is sampled. Total sequence length is L*N/2 butterflies.
REQ-021 o_valid deasserts after the last accept unless a new sequence refills B. No bubble between stages.
REQ-022 Outputs are held unchanged while o_valid && !i_ready.
REQ-023 A start in the o_done cycle is accepted (state is IDLE that cycle).

Reset
REQ-024 With rst_n low at a clock edge, the block SHALL clear:
- state to IDLE
- counters to 0
- o_busy, o_done, o_valid and o_last to 0
- o_addr_a, o_addr_b, o_stage and o_tw_num to 0.
REQ-025 Reset mid-sequence SHALL abandon the sequence with no o_done. After reset, a fresh i_start SHALL restart at stage 0, butterfly 0.

Structure
REQ-026 Package fft_pkg holds the FSM state enum and the width functions (AW, TW). The twiddle ROM module and the FFT datapath import the same package.
REQ-027 One sub-module, fft_bfly_addr, holds the combinational REQ-017 math (inputs s and b; outputs addr_a, addr_b and tw). The rest of the logic stays in fft_addr_sched.
REQ-028 No initial blocks. Synthesizable.

Verification
REQ-029 N=8, i_ready=1, one start -> 12 butterflies, each as (a,b,tw):
- s0: (0,4,0), (1,5,1), (2,6,2), (3,7,3)
- s1: (0,2,0), (1,3,2), (4,6,0), (5,7,2)
- s2: (0,1,0), (2,3,0), (4,5,0), (6,7,0)
- o_last on the 12th butterfly; o_done the next cycle.
REQ-030 N=8, i_ready low for 3 cycles while (1,5) is presented -> outputs and o_tw_num=1 held for all 3 cycles, ROM output stays cos/sin index 1, and no butterfly is skipped or duplicated.
REQ-031 N=16, random i_ready with 50% duty -> the accepted sequence equals a reference model of REQ-017, giving 32 butterflies.
REQ-032 rst_n low at butterfly 5 of N=8 -> all outputs 0 the next cycle and no o_done. A subsequent start gives the full REQ-029 sequence.
REQ-033 i_start asserted during ISSUE -> ignored, the sequence is unaltered. i_start in the o_done cycle -> a second sequence follows back-to-back.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer FSM states and derived widths for N-point radix-2.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fft_state_e;

    // Address / stage width for an N-point transform.
    function automatic int fft_aw(input int n);
        return $clog2(n);
    endfunction

    // Twiddle index width: N/2 distinct twiddles.
    function automatic int fft_tw(input int n);
        return $clog2(n) - 1;
    endfunction

endpackage

// File: rtl/fft_bfly_addr.sv
// Radix-2 DIF butterfly address and twiddle index for stage s, butterfly b.
// Group/offset split is done with a mask since the half-span h is a power of two.
module fft_bfly_addr
    import fft_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [fft_aw(N)-1:0] i_stage,
    input  logic [fft_aw(N)-2:0] i_bfly,
    output logic [fft_aw(N)-1:0] o_addr_a,
    output logic [fft_aw(N)-1:0] o_addr_b,
    output logic [fft_tw(N)-1:0] o_tw
);

    localparam int AW = fft_aw(N);
    localparam int BW = AW - 1;
    localparam logic [AW-1:0] HALF = AW'(N / 2);

    logic [AW-1:0] h;
    logic [BW-1:0] mask;
    logic [BW-1:0] j;

    // h = N >> (s+1); j = b mod h; g*2h = (b - j) << 1; tw = j << s.
    always_comb begin
        h        = HALF >> i_stage;
        mask     = BW'(h - AW'(1));
        j        = i_bfly & mask;
        o_addr_a = {i_bfly & ~mask, 1'b0} | {1'b0, j};
        o_addr_b = o_addr_a | h;
        o_tw     = j << i_stage;
    end

endmodule

// File: rtl/fft_addr_sched.sv
// FFT address scheduler: walks all L*N/2 DIF butterflies through a counter stage (A)
// and an output register (B) with valid/ready backpressure. o_tw_num runs one
// butterfly ahead so a 1-cycle twiddle ROM lines up with o_valid, stalls included.
module fft_addr_sched
    import fft_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [fft_tw(N)-1:0] o_tw_num,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [fft_aw(N)-1:0] o_addr_a,
    output logic [fft_aw(N)-1:0] o_addr_b,
    output logic [fft_aw(N)-1:0] o_stage,
    output logic                 o_last
);

    localparam int L  = $clog2(N);
    localparam int AW = fft_aw(N);
    localparam int TW = fft_tw(N);
    localparam int BW = L - 1;
    localparam logic [AW-1:0] LAST_S = AW'(L - 1);
    localparam logic [BW-1:0] LAST_B = '1;

    fft_state_e state_q, state_d;

    // Stage A: next butterfly to present
    logic [AW-1:0] s_q, s_d;
    logic [BW-1:0] b_q, b_d;

    // Stage B: presented butterfly
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic [AW-1:0] stage_q, stage_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [TW-1:0] tw_b_q, tw_b_d;
    logic          done_q, done_d;

    logic          advance;
    logic          a_last;
    logic [AW-1:0] addr_a_a, addr_b_a;
    logic [TW-1:0] tw_a;

    fft_bfly_addr #(.N(N)) u_bfly (
        .i_stage  (s_q),
        .i_bfly   (b_q),
        .o_addr_a (addr_a_a),
        .o_addr_b (addr_b_a),
        .o_tw     (tw_a)
    );

    // Pipe moves whenever B is empty or its butterfly is being taken
    always_comb begin
        advance = !vld_q || i_ready;
        a_last  = (s_q == LAST_S) && (b_q == LAST_B);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave ISSUE once the final butterfly moves into B
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)            state_d = ISSUE;
            ISSUE:   if (advance && a_last)  state_d = DRAIN;
            DRAIN:   if (vld_q && i_ready)   state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Counter and output-register next values
    always_comb begin
        s_d      = s_q;
        b_d      = b_q;
        vld_d    = vld_q;
        last_d   = last_q;
        stage_d  = stage_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tw_b_d   = tw_b_q;
        done_d   = (state_q == DRAIN) && vld_q && i_ready;
        if (state_q == IDLE && i_start) begin
            s_d = '0;
            b_d = '0;
        end else if (state_q == ISSUE && advance) begin
            b_d = b_q + BW'(1);
            if (b_q == LAST_B)
                s_d = (s_q == LAST_S) ? '0 : s_q + AW'(1);
        end
        if (advance) begin
            vld_d    = (state_q == ISSUE);
            last_d   = (state_q == ISSUE) && a_last;
            stage_d  = s_q;
            addr_a_d = addr_a_a;
            addr_b_d = addr_b_a;
            tw_b_d   = tw_a;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q      <= '0;
            b_q      <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            stage_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_b_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            s_q      <= s_d;
            b_q      <= b_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            stage_q  <= stage_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_b_q   <= tw_b_d;
            done_q   <= done_d;
        end
    end

    // Outputs; twiddle index leads by one butterfly unless B is stalled
    always_comb begin
        o_busy   = (state_q != IDLE);
        o_done   = done_q;
        o_valid  = vld_q;
        o_last   = last_q;
        o_stage  = stage_q;
        o_addr_a = addr_a_q;
        o_addr_b = addr_b_q;
        o_tw_num = advance ? tw_a : tw_b_q;
    end

endmodule

// File: tb/tb_fft_addr_sched.sv
// Directed bench for fft_addr_sched: N=8 tables, stall, restart, reset, N=16 random ready.
module tb_fft_addr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start8, i_ready8, i_start16, i_ready16;
    logic       busy8, done8, valid8, last8;
    logic [1:0] tw8;
    logic [2:0] a8, b8, st8;
    logic       busy16, done16, valid16, last16;
    logic [2:0] tw16;
    logic [3:0] a16, b16, st16;
    logic [1:0] rom8_q;
    logic [2:0] rom16_q;

    int vectors = 0;
    int miscompares = 0;

    int ea[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int eb[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int et[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    always #5 clk = ~clk;

    fft_addr_sched #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start8), .o_busy(busy8), .o_done(done8),
        .o_tw_num(tw8), .o_valid(valid8), .i_ready(i_ready8), .o_addr_a(a8),
        .o_addr_b(b8), .o_stage(st8), .o_last(last8)
    );

    fft_addr_sched #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start16), .o_busy(busy16), .o_done(done16),
        .o_tw_num(tw16), .o_valid(valid16), .i_ready(i_ready16), .o_addr_a(a16),
        .o_addr_b(b16), .o_stage(st16), .o_last(last16)
    );

    // Twiddle ROM stand-in: 1-cycle read latency, returns the index it was given
    always @(posedge clk) begin
        rom8_q  <= tw8;
        rom16_q <= tw16;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference using divide/modulo
    function automatic void ref_bfly(input int n, input int idx,
                                     output int ra, output int rb, output int rt, output int rs);
        int bb, h, g, j;
        rs = idx / (n / 2);
        bb = idx % (n / 2);
        h  = n >> (rs + 1);
        g  = bb / h;
        j  = bb % h;
        ra = g * 2 * h + j;
        rb = ra + h;
        rt = (j << rs) % (n / 2);
    endfunction

    // Caller has just raised i_start8 at a negedge. Runs one N=8 sequence with an
    // optional stall, an optional i_start poke during ISSUE, and optional restart at o_done.
    task automatic seq8(input int stall_at, input int stall_len, input int poke_at, input bit restart);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        @(negedge clk);
        i_start8 = 1'b0;
        #1;
        chk("busy_after_start", busy8, 1);
        chk("no_valid_yet", valid8, 0);
        while (idx < 12 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_start8 = (idx == poke_at);
            if (idx == stall_at && stalled < stall_len) begin
                i_ready8 = 1'b0;
                stalled++;
            end else begin
                i_ready8 = 1'b1;
            end
            #1;
            chk("valid_cont", valid8, 1);
            chk("addr_a", a8, ea[idx]);
            chk("addr_b", b8, eb[idx]);
            chk("stage", st8, idx / 4);
            chk("last", last8, (idx == 11));
            chk("rom_tw", rom8_q, et[idx]);
            if (!i_ready8) chk("tw_held", tw8, et[idx]);
            if (i_ready8) idx++;
        end
        if (cyc >= 60) chk("seq8_timeout", cyc, 0);
        chk("stalls_seen", stalled, stall_len);
        @(negedge clk);
        i_start8 = restart;
        i_ready8 = 1'b1;
        #1;
        chk("done_pulse", done8, 1);
        chk("valid_off", valid8, 0);
        chk("busy_off", busy8, 0);
        if (!restart) begin
            @(negedge clk);
            #1;
            chk("done_one_cycle", done8, 0);
        end
    endtask

    initial begin
        int acc, cyc, ra, rb, rt, rs;
        rst_n = 1'b0;
        i_start8 = 1'b0; i_ready8 = 1'b1;
        i_start16 = 1'b0; i_ready16 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_valid", valid8, 0);
        chk("rst_last", last8, 0);
        chk("rst_addr_a", a8, 0);
        chk("rst_addr_b", b8, 0);
        chk("rst_stage", st8, 0);
        chk("rst_tw", tw8, 0);
        chk("rst_valid16", valid16, 0);
        chk("rst_done16", done16, 0);
        rst_n = 1'b1;

        // Plain sequence
        @(negedge clk); i_start8 = 1'b1;
        seq8(-1, 0, -1, 1'b0);

        // Stall 3 cycles on (1,5)
        @(negedge clk); i_start8 = 1'b1;
        seq8(1, 3, -1, 1'b0);

        // Start poked during ISSUE, then a start in the o_done cycle
        @(negedge clk); i_start8 = 1'b1;
        seq8(-1, 0, 3, 1'b1);
        seq8(-1, 0, -1, 1'b0);

        // Reset while butterfly 5 is presented
        @(negedge clk); i_start8 = 1'b1;
        @(negedge clk); i_start8 = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_rst_a", a8, ea[5]);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", valid8, 0);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_a", a8, 0);
        chk("mid_rst_b", b8, 0);
        chk("mid_rst_stage", st8, 0);
        chk("mid_rst_tw", tw8, 0);
        chk("mid_rst_last", last8, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("no_done_after_rst", done8, 0);
        end
        @(negedge clk); i_start8 = 1'b1;
        seq8(-1, 0, -1, 1'b0);

        // N=16 with random backpressure
        @(negedge clk); i_start16 = 1'b1;
        @(negedge clk); i_start16 = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 32 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_ready16 = 1'($urandom_range(0, 1));
            #1;
            if (valid16) begin
                ref_bfly(16, acc, ra, rb, rt, rs);
                chk("n16_rom_tw", rom16_q, rt);
                if (!i_ready16) chk("n16_tw_held", tw16, rt);
                if (i_ready16) begin
                    chk("n16_a", a16, ra);
                    chk("n16_b", b16, rb);
                    chk("n16_stage", st16, rs);
                    chk("n16_last", last16, (acc == 31));
                    acc++;
                end
            end
        end
        chk("n16_count", acc, 32);
        @(negedge clk);
        i_ready16 = 1'b1;
        #1;
        chk("n16_done", done16, 1);
        chk("n16_valid_off", valid16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
